// File: rtl/pll_lock_reset_gen_if.sv
// pll_lock_reset_gen_if
// Bundles the lock input, the status-clear strobe and all outputs of
// pll_lock_reset_gen.
//   slave  : the generator (consumes locked/clear_status, drives the rest)
//   master : whoever drives locked/clear_status and observes the outputs
// Signals:
//   locked          PLL lock flag, asynchronous to the generator clock
//   clear_status    single-cycle pulse clearing lock_loss_count/timeout_flag
//   sys_reset       active-high fabric reset
//   ready           high only while the lock is accepted and running
//   pll_resetb      active-low PLL reset request
//   lock_loss_count saturating lock-loss count
//   timeout_flag    sticky lock-acquisition timeout flag
interface pll_lock_reset_gen_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             locked;
    logic             clear_status;
    logic             sys_reset;
    logic             ready;
    logic             pll_resetb;
    logic [CNT_W-1:0] lock_loss_count;
    logic             timeout_flag;

    modport master (
        output locked, clear_status,
        input  sys_reset, ready, pll_resetb, lock_loss_count, timeout_flag
    );

    modport slave (
        input  locked, clear_status,
        output sys_reset, ready, pll_resetb, lock_loss_count, timeout_flag
    );
endinterface

// File: rtl/pll_lock_reset_gen.sv
// pll_lock_reset_gen
// Turns the asynchronous PLL lock flag into a debounced active-high fabric
// reset and a ready flag, counts lock losses seen while running and flags
// lock-acquisition timeouts. Runs on the PLL output clock.
// Optional feature macro: PLL_AUTO_RELOCK_EN -- a timeout pulses pll_resetb
// low for PLL_RESET_CYCLES cycles before acquisition resumes. Without it the
// PLL reset state is absent and pll_resetb is held at 1.
// Ports:
//   clock_i  PLL output clock
//   reset_i  synchronous active-high block reset
//   bus      pll_lock_reset_gen_if.slave (locked, clear_status in; sys_reset,
//            ready, pll_resetb, lock_loss_count, timeout_flag out)
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_WAIT   | acquiring: counting consecutive lock cycles, timeout running
// S_HOLD   | lock accepted, sys_reset still held for RESET_HOLD cycles
// S_RUN    | fabric released, ready = 1
// S_PLLRST | pll_resetb pulsed low (PLL_AUTO_RELOCK_EN builds only)
module pll_lock_reset_gen #(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned STABLE_CYCLES    = 1024,
    parameter int unsigned RESET_HOLD       = 16,
    parameter int unsigned TIMEOUT_CYCLES   = 65536,
    parameter int unsigned PLL_RESET_CYCLES = 8,
    parameter int unsigned CNT_W            = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    pll_lock_reset_gen_if.slave  bus
);
    // A single-flop synchroniser is never acceptable; clamp to two.
    localparam int unsigned SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned STABLE_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned HOLD_W   = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RESET_HOLD - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_HOLD   = 2'd1,
        S_RUN    = 2'd2
`ifdef PLL_AUTO_RELOCK_EN
        ,
        S_PLLRST = 2'd3
`endif
    } state_t;

    state_t              state_q;
    logic [SYNC_N-1:0]   sync_q;
    logic [STABLE_W-1:0] stable_cnt_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [TMO_W-1:0]    timeout_cnt_q;
    logic                sys_reset_q;
    logic                ready_q;
    logic [CNT_W-1:0]    loss_cnt_q;
    logic                timeout_flag_q;

    logic lk;
    logic accept;
    logic timeout_hit;
    logic loss_evt;

    assign lk          = sync_q[SYNC_N-1];
    assign accept      = (state_q == S_WAIT) && lk && (stable_cnt_q == STABLE_LAST);
    // Acceptance on the terminal timeout cycle suppresses the timeout.
    assign timeout_hit = (state_q == S_WAIT) && !accept && (timeout_cnt_q == TMO_LAST);
    assign loss_evt    = (state_q == S_RUN) && !lk;

`ifdef PLL_AUTO_RELOCK_EN
    localparam int unsigned PR_W = (PLL_RESET_CYCLES > 1) ? $clog2(PLL_RESET_CYCLES) : 1;
    localparam logic [PR_W-1:0] PR_LAST = PR_W'(PLL_RESET_CYCLES - 1);

    logic [PR_W-1:0] pll_cnt_q;
    logic            pll_resetb_q;

    assign bus.pll_resetb = pll_resetb_q;
`else
    // No relock pulse in this build; the pulse length only keeps the
    // parameter referenced and does not affect the constant.
    assign bus.pll_resetb = (PLL_RESET_CYCLES != 0) | 1'b1;
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= S_WAIT;
            sync_q         <= '0;
            stable_cnt_q   <= '0;
            hold_cnt_q     <= '0;
            timeout_cnt_q  <= '0;
            sys_reset_q    <= 1'b1;
            ready_q        <= 1'b0;
            loss_cnt_q     <= '0;
            timeout_flag_q <= 1'b0;
`ifdef PLL_AUTO_RELOCK_EN
            pll_cnt_q      <= '0;
            pll_resetb_q   <= 1'b1;
`endif
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], bus.locked};

            // A loss coinciding with a clear counts as the first new loss.
            if (loss_evt) begin
                if (bus.clear_status)
                    loss_cnt_q <= CNT_W'(1);
                else if (loss_cnt_q != CNT_MAX)
                    loss_cnt_q <= loss_cnt_q + 1'b1;
            end else if (bus.clear_status) begin
                loss_cnt_q <= '0;
            end

            if (timeout_hit)
                timeout_flag_q <= 1'b1;
            else if (bus.clear_status)
                timeout_flag_q <= 1'b0;

            case (state_q)
                S_WAIT: begin
                    if (accept) begin
                        state_q       <= S_HOLD;
                        stable_cnt_q  <= '0;
                        timeout_cnt_q <= '0;
                    end else begin
                        stable_cnt_q <= lk ? stable_cnt_q + 1'b1 : '0;
                        if (timeout_hit) begin
                            timeout_cnt_q <= '0;
`ifdef PLL_AUTO_RELOCK_EN
                            stable_cnt_q  <= '0;
                            pll_cnt_q     <= '0;
                            pll_resetb_q  <= 1'b0;
                            state_q       <= S_PLLRST;
`endif
                        end else begin
                            timeout_cnt_q <= timeout_cnt_q + 1'b1;
                        end
                    end
                end

                S_HOLD: begin
                    if (!lk) begin
                        state_q    <= S_WAIT;
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q     <= S_RUN;
                        hold_cnt_q  <= '0;
                        sys_reset_q <= 1'b0;
                        ready_q     <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end

                S_RUN: begin
                    if (!lk) begin
                        state_q     <= S_WAIT;
                        sys_reset_q <= 1'b1;
                        ready_q     <= 1'b0;
                    end
                end

`ifdef PLL_AUTO_RELOCK_EN
                S_PLLRST: begin
                    if (pll_cnt_q == PR_LAST) begin
                        state_q      <= S_WAIT;
                        pll_cnt_q    <= '0;
                        pll_resetb_q <= 1'b1;
                    end else begin
                        pll_cnt_q <= pll_cnt_q + 1'b1;
                    end
                end
`endif

                default: begin
                    state_q       <= S_WAIT;
                    stable_cnt_q  <= '0;
                    hold_cnt_q    <= '0;
                    timeout_cnt_q <= '0;
                    sys_reset_q   <= 1'b1;
                    ready_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sys_reset       = sys_reset_q;
    assign bus.ready           = ready_q;
    assign bus.lock_loss_count = loss_cnt_q;
    assign bus.timeout_flag    = timeout_flag_q;

endmodule

// File: tb/tb_pll_lock_reset_gen.sv
// tb_pll_lock_reset_gen
// Self-checking bench for pll_lock_reset_gen with small parameters:
// a segment table for the clean-lock / loss / relock flow, directed
// sequences for glitches, saturation, timeout and mid-run reset, then a
// randomized run compared every cycle against a run-length based model.
module tb_pll_lock_reset_gen;
    localparam int SYNC    = 2;
    localparam int STABLE  = 16;
    localparam int HOLD    = 4;
    localparam int TMO     = 64;
    localparam int PLLR    = 8;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int LAT     = SYNC + STABLE + HOLD;
`ifdef PLL_AUTO_RELOCK_EN
    localparam int SECOND_TMO = TMO + PLLR + TMO;
`else
    localparam int SECOND_TMO = 2 * TMO;
`endif

    logic clk;
    logic rst;

    pll_lock_reset_gen_if #(.CNT_W(CW)) bus ();

    pll_lock_reset_gen #(
        .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .RESET_HOLD(HOLD),
        .TIMEOUT_CYCLES(TMO), .PLL_RESET_CYCLES(PLLR), .CNT_W(CW)
    ) dut (
        .clock_i(clk),
        .reset_i(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit mdl_chk = 0;

    // reference model: lk history, run length of consecutive lk=1 while
    // not running, cycles spent acquiring, remaining relock pulse cycles
    logic [SYNC-1:0] m_hist;
    bit m_run;
    int m_len, m_age, m_pll, m_cnt;
    bit m_flag;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int sr, input int rdy,
                           input int cnt, input int flag, input int pllb);
        check({tag, " sys_reset"}, int'(bus.sys_reset), sr);
        check({tag, " ready"}, int'(bus.ready), rdy);
        check({tag, " count"}, int'(bus.lock_loss_count), cnt);
        check({tag, " timeout_flag"}, int'(bus.timeout_flag), flag);
        check({tag, " pll_resetb"}, int'(bus.pll_resetb), pllb);
    endtask

    task automatic model_edge(input logic lk_in, input logic clr_in, input logic rst_in);
        logic lk;
        bit loss;
        bit tmo;
        if (rst_in) begin
            m_hist = '0; m_run = 0; m_len = 0; m_age = 0; m_pll = 0;
            m_cnt = 0; m_flag = 0;
            return;
        end
        lk     = m_hist[SYNC-1];
        m_hist = {m_hist[SYNC-2:0], lk_in};
        loss = 0;
        tmo  = 0;
        if (m_run) begin
            if (!lk) begin
                m_run = 0; loss = 1; m_len = 0; m_age = 0;
            end
        end else if (m_pll > 0) begin
            m_pll--;
        end else if (m_len >= STABLE) begin
            if (!lk) m_len = 0;
            else begin
                m_len++;
                if (m_len == STABLE + HOLD) m_run = 1;
            end
        end else begin
            if (lk && m_len == STABLE - 1) begin
                m_len = STABLE; m_age = 0;
            end else begin
                m_len = lk ? m_len + 1 : 0;
                if (m_age == TMO - 1) begin
                    tmo = 1; m_age = 0;
`ifdef PLL_AUTO_RELOCK_EN
                    m_pll = PLLR; m_len = 0;
`endif
                end else begin
                    m_age++;
                end
            end
        end
        if (loss) m_cnt = clr_in ? 1 : ((m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1);
        else if (clr_in) m_cnt = 0;
        if (tmo) m_flag = 1;
        else if (clr_in) m_flag = 0;
    endtask

    task automatic step(input logic lk_in, input logic clr_in, input logic rst_in);
        bus.locked       = lk_in;
        bus.clear_status = clr_in;
        rst              = rst_in;
        @(posedge clk);
        model_edge(lk_in, clr_in, rst_in);
        #1;
        if (mdl_chk)
            chk_all("model", int'(!m_run), int'(m_run), m_cnt, int'(m_flag),
                    int'(m_pll == 0));
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    // one-cycle drop while running, loss visible three edges later, then relock
    task automatic lose_relock(input logic clr, input int exp_cnt, input string tag);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, clr, 1'b0);
        check({tag, " loss sys_reset"}, int'(bus.sys_reset), 1);
        check({tag, " loss count"}, int'(bus.lock_loss_count), exp_cnt);
        for (int i = 0; i < LAT - 3; i++) step(1'b1, 1'b0, 1'b0);
        check({tag, " relock early ready"}, int'(bus.ready), 0);
        step(1'b1, 1'b0, 1'b0);
        check({tag, " relock ready"}, int'(bus.ready), 1);
    endtask

    typedef struct {
        logic lk;
        logic clr;
        int   n;
        int   sr;
        int   rdy;
        int   cnt;
    } vec_t;

    vec_t tbl [0:7];

    initial begin
        logic cur;
        int   low_left;

        tbl[0] = '{1'b1, 1'b0, LAT - 1, 1, 0, 0};
        tbl[1] = '{1'b1, 1'b0, 1,       0, 1, 0};
        tbl[2] = '{1'b0, 1'b0, 1,       0, 1, 0};
        tbl[3] = '{1'b1, 1'b0, 1,       0, 1, 0};
        tbl[4] = '{1'b1, 1'b0, 1,       1, 0, 1};
        tbl[5] = '{1'b1, 1'b0, LAT - 3, 1, 0, 1};
        tbl[6] = '{1'b1, 1'b0, 1,       0, 1, 1};
        tbl[7] = '{1'b1, 1'b1, 1,       0, 1, 0};

        bus.locked = 1'b0;
        bus.clear_status = 1'b0;
        rst = 1'b1;

        // reset state
        do_reset();
        chk_all("reset", 1, 0, 0, 0, 1);

        // clean lock, one-cycle loss, relock, clear
        foreach (tbl[k]) begin
            for (int i = 0; i < tbl[k].n; i++) step(tbl[k].lk, tbl[k].clr, 1'b0);
            chk_all($sformatf("tbl%0d", k), tbl[k].sr, tbl[k].rdy, tbl[k].cnt, 0, 1);
        end

        // glitchy acquisition: 10 high, 1 low, then high
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < LAT - 1; i++) step(1'b1, 1'b0, 1'b0);
        check("glitch early ready", int'(bus.ready), 0);
        step(1'b1, 1'b0, 1'b0);
        check("glitch ready", int'(bus.ready), 1);
        check("glitch sys_reset", int'(bus.sys_reset), 0);
        check("glitch count", int'(bus.lock_loss_count), 0);

        // saturation, then clear together with a loss
        lose_relock(1'b0, 1, "sat1");
        lose_relock(1'b0, 2, "sat2");
        lose_relock(1'b0, 3, "sat3");
        lose_relock(1'b0, 3, "sat4");
        lose_relock(1'b0, 3, "sat5");
        lose_relock(1'b1, 1, "sat6clr");

        // timeout with locked held low
        do_reset();
        for (int e = 1; e < TMO; e++) step(1'b0, 1'b0, 1'b0);
        check("pre-timeout flag", int'(bus.timeout_flag), 0);
        for (int e = TMO; e < SECOND_TMO; e++) begin
            step(1'b0, 1'b0, 1'b0);
`ifdef PLL_AUTO_RELOCK_EN
            check($sformatf("pll_resetb e%0d", e), int'(bus.pll_resetb),
                  (e < TMO + PLLR) ? 0 : 1);
`else
            check($sformatf("pll_resetb e%0d", e), int'(bus.pll_resetb), 1);
`endif
            check($sformatf("timeout flag e%0d", e), int'(bus.timeout_flag), 1);
            check($sformatf("timeout sys_reset e%0d", e), int'(bus.sys_reset), 1);
        end
        step(1'b0, 1'b1, 1'b0);
        check("flag clear with timeout", int'(bus.timeout_flag), 1);
        step(1'b0, 1'b1, 1'b0);
        check("flag clear", int'(bus.timeout_flag), 0);

        // reset during hold
        do_reset();
        for (int i = 0; i < SYNC + STABLE + 1; i++) step(1'b1, 1'b0, 1'b0);
        check("in hold sys_reset", int'(bus.sys_reset), 1);
        step(1'b1, 1'b0, 1'b1);
        chk_all("rst in hold", 1, 0, 0, 0, 1);
        for (int i = 0; i < LAT - 1; i++) step(1'b1, 1'b0, 1'b0);
        check("after hold rst early ready", int'(bus.ready), 0);
        step(1'b1, 1'b0, 1'b0);
        check("after hold rst ready", int'(bus.ready), 1);

        // reset during run with a nonzero count
        lose_relock(1'b0, 1, "prerst");
        step(1'b1, 1'b0, 1'b1);
        chk_all("rst in run", 1, 0, 0, 0, 1);

        // randomized run against the model
        do_reset();
        mdl_chk  = 1;
        low_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (low_left > 0) begin
                cur = 1'b0;
                low_left--;
            end else if ($urandom_range(0, 29) == 0) begin
                cur = 1'b0;
                low_left = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 140))
                                                        : int'($urandom_range(0, 3));
            end else begin
                cur = 1'b1;
            end
            step(cur, ($urandom_range(0, 63) == 0), 1'b0);
        end
        mdl_chk = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
